fp_class_stream: RTL and testbench

Parametrised, pipelined IEEE-754 classifier with valid/ready streaming and per-class occurrence counters. It generalises the half-precision classifier to any exponent/significand width and adds flow control plus saturating class histograms. It sits in the FP datapath ahead of the arithmetic units and doubles as a self-checking statistics block for exhaustive sweeps.

---
 rtl/fp_class_stream.sv | 169 ++++++++++++++++
 tb/tb_fp_class_stream.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_class_stream.sv
// fp_class_stream: two-stage IEEE-754 class decoder with valid/ready flow control
// and saturating per-class occurrence counters, generic in exponent/significand width.
module fp_class_stream #(
    parameter int NEXP = 5,
    parameter int NSIG = 10,
    parameter int CNTW = 32,
    localparam int W = NEXP + NSIG + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_f,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_f,
    output logic [5:0]      out_class,
    input  logic            count_clr,
    input  logic [2:0]      cnt_sel,
    output logic [CNTW-1:0] cnt_value
);

    localparam int NCNT = 7;

    localparam logic [5:0] CLS_SNAN   = 6'b100000;
    localparam logic [5:0] CLS_QNAN   = 6'b010000;
    localparam logic [5:0] CLS_INF    = 6'b001000;
    localparam logic [5:0] CLS_ZERO   = 6'b000100;
    localparam logic [5:0] CLS_SUB    = 6'b000010;
    localparam logic [5:0] CLS_NORMAL = 6'b000001;

    logic            adv1;
    logic            adv2;
    logic            accept;

    logic            s1_valid_q, s1_valid_d;
    logic [W-1:0]    s1_f_q, s1_f_d;
    logic            s1_e_ones_q, s1_e_ones_d;
    logic            s1_e_zero_q, s1_e_zero_d;
    logic            s1_m_zero_q, s1_m_zero_d;
    logic            s1_m_msb_q, s1_m_msb_d;

    logic            s2_valid_q, s2_valid_d;
    logic [W-1:0]    s2_f_q, s2_f_d;
    logic [5:0]      s2_class_q, s2_class_d;
    logic [5:0]      s1_class;

    logic [NCNT-1:0] cnt_hit;
    logic [CNTW-1:0] cnt_q [NCNT];
    logic [CNTW-1:0] cnt_d [NCNT];

    always_comb begin
        adv2   = !s2_valid_q || out_ready;
        adv1   = !s1_valid_q || adv2;
        accept = s2_valid_q && out_ready;
    end

    assign in_ready = adv1;

    // Stage 1: capture the word and the four field flags the class decode needs.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_f_d      = s1_f_q;
        s1_e_ones_d = s1_e_ones_q;
        s1_e_zero_d = s1_e_zero_q;
        s1_m_zero_d = s1_m_zero_q;
        s1_m_msb_d  = s1_m_msb_q;
        if (adv1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_f_d      = in_f;
                s1_e_ones_d = &in_f[W-2:NSIG];
                s1_e_zero_d = ~|in_f[W-2:NSIG];
                s1_m_zero_d = ~|in_f[NSIG-1:0];
                s1_m_msb_d  = in_f[NSIG-1];
            end
        end
    end

    always_comb begin
        s1_class = CLS_NORMAL;
        if (s1_e_ones_q) begin
            if (s1_m_zero_q) begin
                s1_class = CLS_INF;
            end else if (s1_m_msb_q) begin
                s1_class = CLS_QNAN;
            end else begin
                s1_class = CLS_SNAN;
            end
        end else if (s1_e_zero_q) begin
            s1_class = s1_m_zero_q ? CLS_ZERO : CLS_SUB;
        end
    end

    // Stage 2: the class register is cleared when the stage empties so out_class
    // is zero whenever out_valid is low.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_f_d     = s2_f_q;
        s2_class_d = s2_class_q;
        if (adv2) begin
            s2_valid_d = s1_valid_q;
            s2_class_d = s1_valid_q ? s1_class : 6'b000000;
            if (s1_valid_q) begin
                s2_f_d = s1_f_q;
            end
        end
    end

    // Counter index order follows cnt_sel; index 6 is the total.
    assign cnt_hit = {1'b1, s2_class_q[0], s2_class_q[1], s2_class_q[2],
                      s2_class_q[3], s2_class_q[4], s2_class_q[5]};

    always_comb begin
        for (int i = 0; i < NCNT; i++) begin
            cnt_d[i] = count_clr ? '0 : cnt_q[i];
            if (accept && cnt_hit[i] && (cnt_d[i] != '1)) begin
                cnt_d[i] = cnt_d[i] + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_f_q      <= '0;
            s1_e_ones_q <= 1'b0;
            s1_e_zero_q <= 1'b0;
            s1_m_zero_q <= 1'b0;
            s1_m_msb_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_f_q      <= '0;
            s2_class_q  <= '0;
            for (int i = 0; i < NCNT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_f_q      <= s1_f_d;
            s1_e_ones_q <= s1_e_ones_d;
            s1_e_zero_q <= s1_e_zero_d;
            s1_m_zero_q <= s1_m_zero_d;
            s1_m_msb_q  <= s1_m_msb_d;
            s2_valid_q  <= s2_valid_d;
            s2_f_q      <= s2_f_d;
            s2_class_q  <= s2_class_d;
            for (int i = 0; i < NCNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_f     = s2_f_q;
    assign out_class = s2_class_q;

    always_comb begin
        case (cnt_sel)
            3'd0:    cnt_value = cnt_q[0];
            3'd1:    cnt_value = cnt_q[1];
            3'd2:    cnt_value = cnt_q[2];
            3'd3:    cnt_value = cnt_q[3];
            3'd4:    cnt_value = cnt_q[4];
            3'd5:    cnt_value = cnt_q[5];
            default: cnt_value = cnt_q[6];
        endcase
    end

endmodule

// File: tb/tb_fp_class_stream.sv
// Bench for fp_class_stream: half-precision instance with scoreboard, a CNTW=4
// twin for saturation, and a single-precision instance for directed checks.
module tb_fp_class_stream;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_f;
    logic        out_ready;
    logic        count_clr;
    logic [2:0]  cnt_sel;

    logic        in_ready_h, out_valid_h;
    logic [15:0] out_f_h;
    logic [5:0]  out_class_h;
    logic [31:0] cnt_h;

    logic        in_ready_c, out_valid_c;
    logic [15:0] out_f_c;
    logic [5:0]  out_class_c;
    logic [3:0]  cnt_c;

    logic        in_valid_s, in_ready_s, out_valid_s;
    logic [31:0] in_f_s, out_f_s;
    logic [5:0]  out_class_s;
    logic [31:0] cnt_s;

    int vectors = 0;
    int miscompares = 0;

    logic [21:0] sb_q [$];
    logic [21:0] sb_e;
    logic        stall_v = 1'b0;
    logic [15:0] held_f;
    logic [5:0]  held_c;

    fp_class_stream dut_h (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_h), .in_f(in_f),
        .out_valid(out_valid_h), .out_ready(out_ready), .out_f(out_f_h), .out_class(out_class_h),
        .count_clr(count_clr), .cnt_sel(cnt_sel), .cnt_value(cnt_h)
    );

    fp_class_stream #(.CNTW(4)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c), .in_f(in_f),
        .out_valid(out_valid_c), .out_ready(out_ready), .out_f(out_f_c), .out_class(out_class_c),
        .count_clr(count_clr), .cnt_sel(cnt_sel), .cnt_value(cnt_c)
    );

    fp_class_stream #(.NEXP(8), .NSIG(23)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_s), .in_f(in_f_s),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_f(out_f_s), .out_class(out_class_s),
        .count_clr(count_clr), .cnt_sel(cnt_sel), .cnt_value(cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference class for a half-precision word: {snan,qnan,inf,zero,sub,normal}.
    function automatic logic [5:0] cls16(input logic [15:0] f);
        logic [4:0] e;
        logic [9:0] m;
        e = f[14:10];
        m = f[9:0];
        if (e == 5'd31) begin
            if (m == 10'd0)  return 6'b001000;
            else if (m[9])   return 6'b010000;
            else             return 6'b100000;
        end
        if (e == 5'd0) return (m == 10'd0) ? 6'b000100 : 6'b000010;
        return 6'b000001;
    endfunction

    task automatic push(input logic [15:0] f);
        sb_q.push_back({f, cls16(f)});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input int which, input int sel, input longint exp, input string tag);
        logic [63:0] got;
        cnt_sel = sel[2:0];
        #1;
        got = (which == 0) ? {32'd0, cnt_h} : {60'd0, cnt_c};
        chk($sformatf("%s_sel%0d", tag, sel), got, exp);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (sb_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_drain"}, sb_q.size(), 0);
    endtask

    task automatic clear_counters;
        count_clr = 1'b1;
        tick();
        count_clr = 1'b0;
    endtask

    task automatic sp_word(input logic [31:0] f, input logic [5:0] cls, input string tag);
        in_valid_s = 1'b1;
        in_f_s = f;
        tick();
        in_valid_s = 1'b0;
        tick();
        @(negedge clk);
        chk({tag, "_valid"}, out_valid_s, 1);
        chk({tag, "_f"}, out_f_s, f);
        chk({tag, "_class"}, out_class_s, cls);
        tick();
    endtask

    // Output monitor: scoreboard pops, one-hot/idle checks, stall stability.
    always @(negedge clk) begin
        if (rst) begin
            stall_v = 1'b0;
        end else begin
            if (stall_v) begin
                chk("stall_valid", out_valid_h, 1);
                chk("stall_f", out_f_h, held_f);
                chk("stall_class", out_class_h, held_c);
            end
            if (out_valid_h) chk("onehot", $onehot(out_class_h), 1);
            else             chk("class_idle", out_class_h, 0);
            if (out_valid_c) chk("onehot_c", $onehot(out_class_c), 1);
            else             chk("class_idle_c", out_class_c, 0);
            if (out_valid_h && out_ready) begin
                chk("sb_nonempty", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    sb_e = sb_q.pop_front();
                    chk("sb_f", out_f_h, sb_e[21:6]);
                    chk("sb_class", out_class_h, sb_e[5:0]);
                end
            end
            stall_v = out_valid_h && !out_ready;
            held_f  = out_f_h;
            held_c  = out_class_h;
        end
    end

    logic [15:0] dir_f [6] = '{16'h7C01, 16'h7E00, 16'hFC00, 16'h8000, 16'h0001, 16'h3C00};
    logic [5:0]  dir_c [6] = '{6'b100000, 6'b010000, 6'b001000, 6'b000100, 6'b000010, 6'b000001};
    longint      sweep_exp [7] = '{1022, 1024, 2, 2, 2046, 61440, 65536};
    longint      sat_exp [7]   = '{15, 15, 2, 2, 15, 15, 15};

    initial begin
        int          idx;
        int          guard;
        logic        acc;
        logic [15:0] w;

        rst = 1'b1; in_valid = 1'b0; in_f = '0; in_valid_s = 1'b0; in_f_s = '0;
        out_ready = 1'b1; count_clr = 1'b0; cnt_sel = 3'd0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", out_valid_h, 0);
        chk("rst_out_class", out_class_h, 0);
        chk("rst_out_f", out_f_h, 0);
        chk("rst_in_ready", in_ready_h, 1);
        chk("rst_in_ready_c", in_ready_c, 1);
        chk("rst_in_ready_s", in_ready_s, 1);
        chk("rst_out_valid_s", out_valid_s, 0);
        for (int s = 0; s < 8; s++) check_cnt(0, s, 0, "rst_cnt");
        chk("rst_cnt_s", cnt_s, 0);

        // Directed half-precision words with latency check
        for (int k = 0; k < 6; k++) begin
            tick();
            in_valid = 1'b1;
            in_f = dir_f[k];
            push(dir_f[k]);
            tick();
            in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("dir%0d_early", k), out_valid_h, 0);
            @(negedge clk);
            chk($sformatf("dir%0d_valid", k), out_valid_h, 1);
            chk($sformatf("dir%0d_f", k), out_f_h, dir_f[k]);
            chk($sformatf("dir%0d_f_c", k), out_f_c, dir_f[k]);
            chk($sformatf("dir%0d_class", k), out_class_h, dir_c[k]);
        end
        tick();
        drain("dir");

        // Exhaustive sweep, back to back
        clear_counters();
        in_valid = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            in_f = i[15:0];
            push(in_f);
            @(negedge clk);
            if (i >= 2) chk("no_bubble", out_valid_h, 1);
            @(posedge clk);
            #1;
        end
        drain("sweep");
        for (int s = 0; s < 7; s++) check_cnt(0, s, sweep_exp[s], "sweep_cnt");
        check_cnt(0, 7, 65536, "sweep_cnt");
        for (int s = 0; s < 7; s++) check_cnt(1, s, sat_exp[s], "sweep_sat");

        // Random backpressure stream
        tick();
        clear_counters();
        idx = 0;
        guard = 0;
        w = 16'($urandom_range(0, 65535));
        while (idx < 1000 && guard < 20000) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            in_f = w;
            @(negedge clk);
            acc = in_ready_h;
            @(posedge clk);
            #1;
            if (acc) begin
                push(w);
                idx++;
                w = 16'($urandom_range(0, 65535));
            end
            guard++;
        end
        chk("rand_accepted", idx, 1000);
        drain("rand");
        check_cnt(0, 6, 1000, "rand_total");
        check_cnt(0, 7, 1000, "rand_total");

        // Saturation on the CNTW=4 twin
        tick();
        clear_counters();
        in_valid = 1'b1;
        in_f = 16'h3C00;
        for (int i = 0; i < 20; i++) begin
            push(16'h3C00);
            tick();
        end
        drain("sat");
        check_cnt(1, 5, 15, "sat_normal");
        check_cnt(1, 6, 15, "sat_total");
        check_cnt(0, 5, 20, "sat_wide_normal");

        // Clear coinciding with an accept
        tick();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_f = 16'h3C00;
        push(16'h3C00);
        tick();
        in_valid = 1'b0;
        tick();
        count_clr = 1'b1;
        out_ready = 1'b1;
        tick();
        count_clr = 1'b0;
        for (int s = 0; s < 5; s++) check_cnt(1, s, 0, "clr_c");
        check_cnt(1, 5, 1, "clr_c");
        check_cnt(1, 6, 1, "clr_c");
        check_cnt(0, 4, 0, "clr_h");
        check_cnt(0, 5, 1, "clr_h");
        check_cnt(0, 6, 1, "clr_h");

        // Single precision
        tick();
        sp_word(32'h7FC00000, 6'b010000, "sp_qnan");
        sp_word(32'h7F800001, 6'b100000, "sp_snan");
        sp_word(32'hFF800000, 6'b001000, "sp_inf");
        sp_word(32'h80000000, 6'b000100, "sp_zero");
        sp_word(32'h00000001, 6'b000010, "sp_sub");
        sp_word(32'h3F800000, 6'b000001, "sp_normal");

        // Backpressure then reset with both stages full
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_f = 16'h1234;
        push(16'h1234);
        tick();
        in_f = 16'h7E55;
        push(16'h7E55);
        tick();
        in_f = 16'h0042;
        @(negedge clk);
        chk("bp_in_ready", in_ready_h, 0);
        chk("bp_in_ready_c", in_ready_c, 0);
        #1 out_ready = 1'b1;
        #1 chk("bp_release", in_ready_h, 1);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
        chk("mid_rst_valid", out_valid_h, 0);
        chk("mid_rst_class", out_class_h, 0);
        chk("mid_rst_in_ready", in_ready_h, 1);
        check_cnt(0, 6, 0, "mid_rst_total");
        check_cnt(0, 5, 0, "mid_rst_normal");
        out_ready = 1'b1;
        tick();
        in_valid = 1'b1;
        in_f = 16'h4500;
        push(16'h4500);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_early", out_valid_h, 0);
        @(negedge clk);
        chk("post_rst_valid", out_valid_h, 1);
        chk("post_rst_f", out_f_h, 16'h4500);
        tick();
        drain("post_rst");
        check_cnt(0, 6, 1, "post_rst_total");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
